pcie_dllp_fc_init: RTL and testbench

// - Flow-control initialization sequencer for VC0.
// - Sits between the DLLP decoder/encoder and the data-link init FSM.
// - On init_flow_control_i it repeatedly transmits InitFC1 then InitFC2 DLLPs (P, NP, Cpl).
// - It captures the partner's advertised credits and reports the FC1/FC2 stored flags

---
 rtl/pcie_dllp_fc_init.sv | 170 +++++++++++++++++
 tb/tb_pcie_dllp_fc_init.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dllp_fc_init.sv
// VC0 flow-control init sequencer: sends InitFC1/InitFC2 P/NP/Cpl and captures partner credits.
// Latency: rx updates limits/flags on the next edge; tx payload holds until ready (valid drops on clear).
module pcie_dllp_fc_init #(
  parameter logic [7:0]  ADV_P_HDR     = 8'd32,
  parameter logic [11:0] ADV_P_DATA    = 12'd256,
  parameter logic [7:0]  ADV_NP_HDR    = 8'd32,
  parameter logic [11:0] ADV_NP_DATA   = 12'd0,
  parameter logic [7:0]  ADV_CPL_HDR   = 8'd0,
  parameter logic [11:0] ADV_CPL_DATA  = 12'd0,
  parameter int          RESEND_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_flow_control_i,
  input  logic        soft_reset_i,
  input  logic        rx_dllp_valid_i,
  input  logic [7:0]  rx_dllp_type_i,
  input  logic [7:0]  rx_hdr_fc_i,
  input  logic [11:0] rx_data_fc_i,
  input  logic        rx_tlp_valid_i,
  output logic        tx_dllp_valid_o,
  input  logic        tx_dllp_ready_i,
  output logic [7:0]  tx_dllp_type_o,
  output logic [7:0]  tx_hdr_fc_o,
  output logic [11:0] tx_data_fc_o,
  output logic        fc1_values_stored_o,
  output logic        fc2_values_stored_o,
  output logic [7:0]  p_hdr_lim_o,
  output logic [7:0]  np_hdr_lim_o,
  output logic [7:0]  cpl_hdr_lim_o,
  output logic [11:0] p_data_lim_o,
  output logic [11:0] np_data_lim_o,
  output logic [11:0] cpl_data_lim_o
);

  localparam int TW = $clog2(RESEND_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RESEND_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FC1, S_FC2, S_DONE} state_t;
  state_t state_q, state_d;

  logic          tx_vld_q, kick_q, seq_done_q, fi2_q, fc1_q, fc2_q;
  logic [1:0]    tx_idx_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    mask_q;
  logic [7:0]    p_hdr_q, np_hdr_q, cpl_hdr_q;
  logic [11:0]   p_data_q, np_data_q, cpl_data_q;

  logic       clear, cpl_hs, seq_done_d, fi2_d, fi2_hit;
  logic [2:0] fc1_hit, fc1_new, mask_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    clear      = soft_reset_i | ~init_flow_control_i;
    cpl_hs     = tx_vld_q & tx_dllp_ready_i & (tx_idx_q == 2'd2);
    seq_done_d = seq_done_q | cpl_hs;
    fc1_hit[0] = rx_dllp_valid_i & (rx_dllp_type_i == 8'h40);
    fc1_hit[1] = rx_dllp_valid_i & (rx_dllp_type_i == 8'h50);
    fc1_hit[2] = rx_dllp_valid_i & (rx_dllp_type_i == 8'h60);
    fc1_new    = (state_q == S_FC1) ? (fc1_hit & ~mask_q) : 3'b000;
    mask_d     = mask_q | fc1_new;
    fi2_hit    = rx_tlp_valid_i |
                 (rx_dllp_valid_i & (rx_dllp_type_i inside {8'hC0, 8'hD0, 8'hE0,
                                                            8'h80, 8'h90, 8'hA0}));
    fi2_d      = fi2_q | ((state_q == S_FC2) & fi2_hit);
    state_d    = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FC1;
      S_FC1:   if (mask_d == 3'b111 && seq_done_d) state_d = S_FC2;
      S_FC2:   if (fi2_d && seq_done_d) state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear) begin
      tx_vld_q   <= 1'b0;
      kick_q     <= 1'b0;
      seq_done_q <= 1'b0;
      fi2_q      <= 1'b0;
      fc1_q      <= 1'b0;
      fc2_q      <= 1'b0;
      tx_idx_q   <= 2'd0;
      timer_q    <= '0;
      mask_q     <= 3'b000;
      p_hdr_q    <= 8'd0;
      np_hdr_q   <= 8'd0;
      cpl_hdr_q  <= 8'd0;
      p_data_q   <= 12'd0;
      np_data_q  <= 12'd0;
      cpl_data_q <= 12'd0;
    end else begin
      mask_q <= mask_d;
      fi2_q  <= fi2_d;
      if (fc1_new[0]) begin p_hdr_q   <= rx_hdr_fc_i; p_data_q   <= rx_data_fc_i; end
      if (fc1_new[1]) begin np_hdr_q  <= rx_hdr_fc_i; np_data_q  <= rx_data_fc_i; end
      if (fc1_new[2]) begin cpl_hdr_q <= rx_hdr_fc_i; cpl_data_q <= rx_data_fc_i; end
      if (state_q == S_FC1 && state_d == S_FC2)  fc1_q <= 1'b1;
      if (state_q == S_FC2 && state_d == S_DONE) fc2_q <= 1'b1;
      // Every state change restarts the tx sequence one idle cycle later.
      if (state_d != state_q) begin
        tx_vld_q   <= 1'b0;
        tx_idx_q   <= 2'd0;
        timer_q    <= '0;
        kick_q     <= 1'b1;
        seq_done_q <= 1'b0;
      end else if (state_q == S_FC1 || state_q == S_FC2) begin
        seq_done_q <= seq_done_d;
        if (tx_vld_q) begin
          if (tx_dllp_ready_i) begin
            if (tx_idx_q == 2'd2) begin
              tx_vld_q <= 1'b0;
              tx_idx_q <= 2'd0;
              timer_q  <= '0;
            end else begin
              tx_idx_q <= tx_idx_q + 2'd1;
            end
          end
        end else if (kick_q || timer_q == T_LAST) begin
          tx_vld_q <= 1'b1;
          kick_q   <= 1'b0;
          timer_q  <= '0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_dllp_type_o = 8'h00;
    tx_hdr_fc_o    = 8'h00;
    tx_data_fc_o   = 12'h000;
    if (tx_vld_q) begin
      case (tx_idx_q)
        2'd0: begin
          tx_dllp_type_o = (state_q == S_FC2) ? 8'hC0 : 8'h40;
          tx_hdr_fc_o    = ADV_P_HDR;
          tx_data_fc_o   = ADV_P_DATA;
        end
        2'd1: begin
          tx_dllp_type_o = (state_q == S_FC2) ? 8'hD0 : 8'h50;
          tx_hdr_fc_o    = ADV_NP_HDR;
          tx_data_fc_o   = ADV_NP_DATA;
        end
        default: begin
          tx_dllp_type_o = (state_q == S_FC2) ? 8'hE0 : 8'h60;
          tx_hdr_fc_o    = ADV_CPL_HDR;
          tx_data_fc_o   = ADV_CPL_DATA;
        end
      endcase
    end
  end

  assign tx_dllp_valid_o     = tx_vld_q;
  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign p_hdr_lim_o         = p_hdr_q;
  assign np_hdr_lim_o        = np_hdr_q;
  assign cpl_hdr_lim_o       = cpl_hdr_q;
  assign p_data_lim_o        = p_data_q;
  assign np_data_lim_o       = np_data_q;
  assign cpl_data_lim_o      = cpl_data_q;

endmodule

// File: tb/tb_pcie_dllp_fc_init.sv
// Directed bench for pcie_dllp_fc_init with a short resend interval.
module tb_pcie_dllp_fc_init;
  localparam int R = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni, init_flow_control_i, soft_reset_i;
  logic        rx_dllp_valid_i, rx_tlp_valid_i, tx_dllp_ready_i;
  logic [7:0]  rx_dllp_type_i, rx_hdr_fc_i;
  logic [11:0] rx_data_fc_i;
  logic        tx_dllp_valid_o, fc1_values_stored_o, fc2_values_stored_o;
  logic [7:0]  tx_dllp_type_o, tx_hdr_fc_o, p_hdr_lim_o, np_hdr_lim_o, cpl_hdr_lim_o;
  logic [11:0] tx_data_fc_o, p_data_lim_o, np_data_lim_o, cpl_data_lim_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pcie_dllp_fc_init #(.RESEND_CYCLES(R)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .init_flow_control_i(init_flow_control_i), .soft_reset_i(soft_reset_i),
    .rx_dllp_valid_i(rx_dllp_valid_i), .rx_dllp_type_i(rx_dllp_type_i),
    .rx_hdr_fc_i(rx_hdr_fc_i), .rx_data_fc_i(rx_data_fc_i),
    .rx_tlp_valid_i(rx_tlp_valid_i),
    .tx_dllp_valid_o(tx_dllp_valid_o), .tx_dllp_ready_i(tx_dllp_ready_i),
    .tx_dllp_type_o(tx_dllp_type_o), .tx_hdr_fc_o(tx_hdr_fc_o), .tx_data_fc_o(tx_data_fc_o),
    .fc1_values_stored_o(fc1_values_stored_o), .fc2_values_stored_o(fc2_values_stored_o),
    .p_hdr_lim_o(p_hdr_lim_o), .np_hdr_lim_o(np_hdr_lim_o), .cpl_hdr_lim_o(cpl_hdr_lim_o),
    .p_data_lim_o(p_data_lim_o), .np_data_lim_o(np_data_lim_o), .cpl_data_lim_o(cpl_data_lim_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_rx(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    rx_dllp_valid_i = 1'b1;
    rx_dllp_type_i  = t;
    rx_hdr_fc_i     = h;
    rx_data_fc_i    = d;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; init_flow_control_i = 1'b0; soft_reset_i = 1'b0;
    rx_dllp_valid_i = 1'b0; rx_dllp_type_i = 8'h00; rx_hdr_fc_i = 8'h00; rx_data_fc_i = 12'h000;
    rx_tlp_valid_i = 1'b0; tx_dllp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    checks++; if (tx_dllp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", tx_dllp_valid_o); end
    checks++; if ({fc1_values_stored_o, fc2_values_stored_o} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b want 00", {fc1_values_stored_o, fc2_values_stored_o}); end
    checks++; if ({p_hdr_lim_o, p_data_lim_o, np_hdr_lim_o, cpl_data_lim_o} !== 40'h0) begin failures++; $display("FAIL reset_limits: got %h want 0", {p_hdr_lim_o, p_data_lim_o, np_hdr_lim_o, cpl_data_lim_o}); end
  endtask

  task automatic test_tx_sequence();
    int n;
    tx_dllp_ready_i = 1'b1;
    init_flow_control_i = 1'b1;
    tick();
    checks++; if (tx_dllp_valid_o !== 1'b0) begin failures++; $display("FAIL fc1_entry_idle: got %b want 0", tx_dllp_valid_o); end
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o} !== {1'b1, 8'h40, 8'd32, 12'd256}) begin failures++; $display("FAIL tx_p: got %b %h %0d %0d want 1 40 32 256", tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o); end
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o} !== {1'b1, 8'h50, 8'd32, 12'd0}) begin failures++; $display("FAIL tx_np: got %b %h %0d %0d want 1 50 32 0", tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o); end
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o} !== {1'b1, 8'h60, 8'd0, 12'd0}) begin failures++; $display("FAIL tx_cpl: got %b %h %0d %0d want 1 60 0 0", tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o); end
    tick();
    n = 0;
    while (tx_dllp_valid_o === 1'b0 && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n !== R) begin failures++; $display("FAIL resend_gap: got %0d idle cycles want %0d", n, R); end
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'h40}) begin failures++; $display("FAIL resend_type: got %b %h want 1 40", tx_dllp_valid_o, tx_dllp_type_o); end
  endtask

  task automatic test_backpressure();
    int bad;
    tick();
    tx_dllp_ready_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o} !== {1'b1, 8'h50, 8'd32}) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL np_hold: got %0d unstable cycles want 0", bad); end
    tx_dllp_ready_i = 1'b1;
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'h60}) begin failures++; $display("FAIL cpl_after_np: got %b %h want 1 60", tx_dllp_valid_o, tx_dllp_type_o); end
    tick();
    checks++; if (tx_dllp_valid_o !== 1'b0) begin failures++; $display("FAIL idle_after_cpl: got %b want 0", tx_dllp_valid_o); end
  endtask

  task automatic test_fc1_capture();
    init_flow_control_i = 1'b0;
    tick();
    init_flow_control_i = 1'b1;
    tx_dllp_ready_i = 1'b0;
    tick();
    drive_rx(8'h41, 8'd9, 12'd9);
    tick();
    checks++; if ({p_hdr_lim_o, p_data_lim_o} !== {8'd0, 12'd0}) begin failures++; $display("FAIL non_vc0_ignored: got %0d/%0d want 0/0", p_hdr_lim_o, p_data_lim_o); end
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'h40}) begin failures++; $display("FAIL restart_at_p: got %b %h want 1 40", tx_dllp_valid_o, tx_dllp_type_o); end
    drive_rx(8'h40, 8'd8, 12'd64);
    tick();
    checks++; if ({p_hdr_lim_o, p_data_lim_o} !== {8'd8, 12'd64}) begin failures++; $display("FAIL p_capture: got %0d/%0d want 8/64", p_hdr_lim_o, p_data_lim_o); end
    drive_rx(8'h40, 8'd1, 12'd1);
    tick();
    drive_rx(8'hC1, 8'd2, 12'd2);
    tick();
    checks++; if ({p_hdr_lim_o, p_data_lim_o} !== {8'd8, 12'd64}) begin failures++; $display("FAIL p_dup_ignored: got %0d/%0d want 8/64", p_hdr_lim_o, p_data_lim_o); end
    drive_rx(8'h50, 8'd4, 12'd0);
    tick();
    checks++; if ({np_hdr_lim_o, np_data_lim_o} !== {8'd4, 12'd0}) begin failures++; $display("FAIL np_capture: got %0d/%0d want 4/0", np_hdr_lim_o, np_data_lim_o); end
    drive_rx(8'h60, 8'd0, 12'd0);
    tick();
    rx_dllp_valid_i = 1'b0;
    checks++; if ({fc1_values_stored_o, tx_dllp_valid_o, tx_dllp_type_o} !== {1'b0, 1'b1, 8'h40}) begin failures++; $display("FAIL fc1_waits_tx: got %b %b %h want 0 1 40", fc1_values_stored_o, tx_dllp_valid_o, tx_dllp_type_o); end
    tx_dllp_ready_i = 1'b1;
    tick();
    tick();
    checks++; if ({fc1_values_stored_o, tx_dllp_type_o} !== {1'b0, 8'h60}) begin failures++; $display("FAIL fc1_before_cpl_hs: got %b %h want 0 60", fc1_values_stored_o, tx_dllp_type_o); end
    tick();
    checks++; if ({fc1_values_stored_o, tx_dllp_valid_o} !== 2'b10) begin failures++; $display("FAIL fc1_set: got %b %b want 1 0", fc1_values_stored_o, tx_dllp_valid_o); end
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o} !== {1'b1, 8'hC0, 8'd32, 12'd256}) begin failures++; $display("FAIL fc2_tx_p: got %b %h %0d %0d want 1 C0 32 256", tx_dllp_valid_o, tx_dllp_type_o, tx_hdr_fc_o, tx_data_fc_o); end
  endtask

  task automatic test_fc2();
    int any_vld;
    drive_rx(8'h80, 8'd0, 12'd0);
    tick();
    rx_dllp_valid_i = 1'b0;
    checks++; if ({fc2_values_stored_o, tx_dllp_type_o} !== {1'b0, 8'hD0}) begin failures++; $display("FAIL fc2_early: got %b %h want 0 D0", fc2_values_stored_o, tx_dllp_type_o); end
    tick();
    checks++; if ({fc2_values_stored_o, tx_dllp_type_o} !== {1'b0, 8'hE0}) begin failures++; $display("FAIL fc2_before_e0: got %b %h want 0 E0", fc2_values_stored_o, tx_dllp_type_o); end
    tick();
    checks++; if ({fc2_values_stored_o, tx_dllp_valid_o} !== 2'b10) begin failures++; $display("FAIL fc2_set: got %b %b want 1 0", fc2_values_stored_o, tx_dllp_valid_o); end
    any_vld = 0;
    for (int i = 0; i < R + 4; i++) begin
      tick();
      if (tx_dllp_valid_o !== 1'b0) any_vld++;
    end
    checks++; if (any_vld !== 0) begin failures++; $display("FAIL done_silent: got %0d valid cycles want 0", any_vld); end
    checks++; if ({fc1_values_stored_o, p_hdr_lim_o, np_hdr_lim_o} !== {1'b1, 8'd8, 8'd4}) begin failures++; $display("FAIL done_hold: got %b %0d %0d want 1 8 4", fc1_values_stored_o, p_hdr_lim_o, np_hdr_lim_o); end
  endtask

  task automatic test_drop_init();
    init_flow_control_i = 1'b0;
    tick();
    checks++; if ({fc1_values_stored_o, fc2_values_stored_o} !== 2'b00) begin failures++; $display("FAIL done_clear: got %b%b want 00", fc1_values_stored_o, fc2_values_stored_o); end
    init_flow_control_i = 1'b1;
    tick();
    drive_rx(8'h40, 8'd5, 12'd10);
    tick();
    drive_rx(8'h50, 8'd6, 12'd11);
    tick();
    drive_rx(8'h60, 8'd7, 12'd12);
    tick();
    rx_dllp_valid_i = 1'b0;
    tick();
    checks++; if ({fc1_values_stored_o, p_hdr_lim_o, cpl_hdr_lim_o, cpl_data_lim_o} !== {1'b1, 8'd5, 8'd7, 12'd12}) begin failures++; $display("FAIL fc1_mask_with_cpl: got %b %0d %0d %0d want 1 5 7 12", fc1_values_stored_o, p_hdr_lim_o, cpl_hdr_lim_o, cpl_data_lim_o); end
    tick();
    tx_dllp_ready_i = 1'b0;
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'hC0}) begin failures++; $display("FAIL fc2_hold: got %b %h want 1 C0", tx_dllp_valid_o, tx_dllp_type_o); end
    init_flow_control_i = 1'b0;
    tick();
    checks++; if ({tx_dllp_valid_o, fc1_values_stored_o, p_hdr_lim_o, cpl_data_lim_o} !== {1'b0, 1'b0, 8'd0, 12'd0}) begin failures++; $display("FAIL drop_clear: got %b %b %0d %0d want 0 0 0 0", tx_dllp_valid_o, fc1_values_stored_o, p_hdr_lim_o, cpl_data_lim_o); end
    init_flow_control_i = 1'b1;
    tx_dllp_ready_i = 1'b1;
    tick();
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'h40}) begin failures++; $display("FAIL reinit_restart: got %b %h want 1 40", tx_dllp_valid_o, tx_dllp_type_o); end
  endtask

  task automatic test_soft_reset();
    soft_reset_i = 1'b1;
    drive_rx(8'h40, 8'd9, 12'd9);
    tick();
    checks++; if ({tx_dllp_valid_o, p_hdr_lim_o, p_data_lim_o} !== {1'b0, 8'd0, 12'd0}) begin failures++; $display("FAIL soft_reset_priority: got %b %0d %0d want 0 0 0", tx_dllp_valid_o, p_hdr_lim_o, p_data_lim_o); end
    soft_reset_i = 1'b0;
    rx_dllp_valid_i = 1'b0;
    tick();
    tick();
    checks++; if ({tx_dllp_valid_o, tx_dllp_type_o} !== {1'b1, 8'h40}) begin failures++; $display("FAIL soft_reset_restart: got %b %h want 1 40", tx_dllp_valid_o, tx_dllp_type_o); end
    drive_rx(8'h40, 8'd3, 12'd3);
    tick();
    rx_dllp_valid_i = 1'b0;
    checks++; if ({p_hdr_lim_o, p_data_lim_o} !== {8'd3, 12'd3}) begin failures++; $display("FAIL capture_after_soft_reset: got %0d/%0d want 3/3", p_hdr_lim_o, p_data_lim_o); end
  endtask

  initial begin
    test_reset();
    test_tx_sequence();
    test_backpressure();
    test_fc1_capture();
    test_fc2();
    test_drop_init();
    test_soft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
